// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Supervises a PLL through its reset/locked interface from the 50 MHz board
// reference clock. It holds the PLL in reset for a fixed time, then waits for
// a synchronized lock and requires the lock to stay high continuously before
// raising `ready`. A lock timeout, a glitch while qualifying, or a lost lock
// while running is a failed attempt. The PLL is retried until MAX_RETRY
// failures have accumulated. After that the block parks in a terminal fault
// with the PLL held in reset.
//
// Optional feature: define PLL_SUP_FREQ_CHECK_EN to enable an outclk
// frequency check while running. The check counts synchronized pll_outclk
// rising edges per WINDOW refclk cycles. A count outside EXP_EDGES +/- TOL is
// treated like a lost lock, except that lock_lost is not set. The check is
// only meaningful while refclk is faster than twice outclk. When the macro is
// undefined, pll_outclk is ignored.
//
// Ports:
//   refclk      in   reference clock (only clock)
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL locked, asynchronous
//   pll_outclk  in   PLL output clock, sampled as data (frequency check only)
//   pll_rst     out  PLL reset, active-high
//   ready       out  PLL output usable
//   fault       out  retries exhausted, sticky until rst_n
//   lock_lost   out  sticky, set when lock drops while running
//   retry_cnt   out  failed attempts so far, saturates at 15
module pll_lock_supervisor #(
   parameter int RST_CYCLES    = 100,
   parameter int LOCK_TIMEOUT  = 500000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 4,
   parameter int WINDOW        = 50000,
   parameter int EXP_EDGES     = 12288,
   parameter int TOL           = 16
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       pll_outclk,
   output logic       pll_rst,
   output logic       ready,
   output logic       fault,
   output logic       lock_lost,
   output logic [3:0] retry_cnt
);

   typedef enum logic [2:0] {
      S_RESET,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAULT
   } state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Saturating increment for the attempt counter.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // One state counter is shared by RESET, WAIT_LOCK and STABLE. It is sized
   // for the largest of the three terminal counts.
   localparam int CNT_MAX = max_of(max_of(RST_CYCLES, LOCK_TIMEOUT), STABLE_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lock_p0, lock_p1;
   logic             fail;
   logic             lock_fail;
   logic             freq_bad;
   logic [3:0]       retry_nxt;

   assign retry_nxt = sat_inc(retry_cnt);

   // A failure takes priority over any terminal count in the same cycle.
   always_comb begin
      fail      = 1'b0;
      lock_fail = 1'b0;
      case (state)
         S_WAIT_LOCK: fail = !lock_p1 && (cnt == TIMEOUT_END);
         S_STABLE:    fail = !lock_p1;
         S_RUN: begin
            lock_fail = !lock_p1;
            fail      = !lock_p1 || freq_bad;
         end
         default: fail = 1'b0;
      endcase
   end

`ifdef PLL_SUP_FREQ_CHECK_EN
   localparam int EDGE_W = $clog2(WINDOW + 1);
   localparam int TOT_W  = EDGE_W + 1;
   localparam int LO     = EXP_EDGES - TOL;
   localparam int HI     = EXP_EDGES + TOL;

   logic              oc_p0, oc_p1, oc_p2;
   logic              oc_rise;
   logic              win_end;
   logic [EDGE_W-1:0] win_cnt;
   logic [EDGE_W-1:0] edge_cnt;
   logic [TOT_W-1:0]  edge_total;

   assign oc_rise    = oc_p1 & ~oc_p2;
   assign win_end    = (win_cnt == EDGE_W'(WINDOW - 1));
   // The last cycle's edge belongs to the window that is being evaluated.
   assign edge_total = {1'b0, edge_cnt} + TOT_W'(oc_rise);
   assign freq_bad   = (state == S_RUN) && win_end &&
                       ((int'(edge_total) < LO) || (int'(edge_total) > HI));

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         oc_p0    <= 1'b0;
         oc_p1    <= 1'b0;
         oc_p2    <= 1'b0;
         win_cnt  <= '0;
         edge_cnt <= '0;
      end else begin
         // sync stages p0/p1, edge-detect stage p2
         oc_p0 <= pll_outclk;
         oc_p1 <= oc_p0;
         oc_p2 <= oc_p1;
         // Held at zero outside RUN, so each RUN entry starts a fresh window.
         if (state != S_RUN || fail || win_end) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
         end else begin
            win_cnt  <= win_cnt + 1'b1;
            edge_cnt <= edge_cnt + EDGE_W'(oc_rise);
         end
      end
   end
`else
   logic        unused_outclk;
   logic [31:0] unused_cfg;
   assign freq_bad      = 1'b0;
   assign unused_outclk = pll_outclk;
   assign unused_cfg    = 32'(WINDOW ^ EXP_EDGES ^ TOL);
`endif

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_RESET;
         cnt       <= '0;
         lock_p0   <= 1'b0;
         lock_p1   <= 1'b0;
         pll_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
         lock_lost <= 1'b0;
         retry_cnt <= '0;
      end else begin
         // lock synchronizer stages p0/p1
         lock_p0 <= pll_locked;
         lock_p1 <= lock_p0;

         if (fail) begin
            retry_cnt <= retry_nxt;
            cnt       <= '0;
            ready     <= 1'b0;
            pll_rst   <= 1'b1;
            if (lock_fail) lock_lost <= 1'b1;
            if (retry_nxt >= 4'(MAX_RETRY)) begin
               state <= S_FAULT;
               fault <= 1'b1;
            end else begin
               state <= S_RESET;
            end
         end else begin
            case (state)
               S_RESET: begin
                  if (cnt == RST_LAST) begin
                     state   <= S_WAIT_LOCK;
                     cnt     <= '0;
                     pll_rst <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_WAIT_LOCK: begin
                  if (lock_p1) begin
                     state <= S_STABLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_STABLE: begin
                  if (cnt == STABLE_LAST) begin
                     state <= S_RUN;
                     cnt   <= '0;
                     ready <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  // RUN holds until a failure; FAULT is terminal.
                  cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

   logic       refclk;
   logic       rst_n;
   logic       pll_locked;
   logic       pll_outclk;
   logic       pll_rst;
   logic       ready;
   logic       fault;
   logic       lock_lost;
   logic [3:0] retry_cnt;

   int total = 0;
   int bad   = 0;
   int oc_half = 20;

   pll_lock_supervisor #(
      .RST_CYCLES   (100),
      .LOCK_TIMEOUT (200),
      .STABLE_CYCLES(1024),
      .MAX_RETRY    (3),
      .WINDOW       (200),
      .EXP_EDGES    (50),
      .TOL          (2)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked),
      .pll_outclk(pll_outclk),
      .pll_rst   (pll_rst),
      .ready     (ready),
      .fault     (fault),
      .lock_lost (lock_lost),
      .retry_cnt (retry_cnt)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   // Output clock model; the 2 ns offset keeps its edges off refclk edges.
   initial begin
      pll_outclk = 1'b0;
      #2;
      forever #(oc_half) pll_outclk = ~pll_outclk;
   end

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      repeat (3) tick();
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst got=%0b want=1", pll_rst); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", ready); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b want=0", fault); end
      total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL reset_lock_lost got=%0b want=0", lock_lost); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL reset_retry got=%0d want=0", retry_cnt); end
   endtask

   task automatic test_basic_lock();
      int n;
      rst_n = 1'b1;
      n = 0;
      do begin tick(); n++; end while (pll_rst === 1'b1 && n < 1000);
      total++; if (n != 100) begin bad++; $display("FAIL basic_rst_len got=%0d want=100", n); end
      repeat (150) tick();
      pll_locked = 1'b1;
      repeat (1026) tick();
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL basic_ready_early got=%0b want=0", ready); end
      tick();
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%0b want=1", ready); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL basic_retry got=%0d want=0", retry_cnt); end
      total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL basic_pll_rst got=%0b want=0", pll_rst); end
   endtask

   task automatic test_lock_loss();
      int n;
      pll_locked = 1'b0;
      tick(); tick();
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL loss_ready_hold got=%0b want=1", ready); end
      tick();
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL loss_ready got=%0b want=0", ready); end
      total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL loss_lock_lost got=%0b want=1", lock_lost); end
      total++; if (retry_cnt !== 4'd1) begin bad++; $display("FAIL loss_retry got=%0d want=1", retry_cnt); end
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL loss_pll_rst got=%0b want=1", pll_rst); end
      tick(); tick();
      pll_locked = 1'b1;
      n = 2;
      do begin tick(); n++; end while (pll_rst === 1'b1 && n < 1000);
      total++; if (n != 100) begin bad++; $display("FAIL loss_rst_len got=%0d want=100", n); end
      repeat (1024) tick();
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL relock_early got=%0b want=0", ready); end
      tick();
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL relock_ready got=%0b want=1", ready); end
      total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL relock_lock_lost got=%0b want=1", lock_lost); end
      total++; if (retry_cnt !== 4'd1) begin bad++; $display("FAIL relock_retry got=%0d want=1", retry_cnt); end
   endtask

   task automatic test_async_reset();
      int n;
      #2;
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      #1;
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL async_pll_rst got=%0b want=1", pll_rst); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL async_ready got=%0b want=0", ready); end
      total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL async_lock_lost got=%0b want=0", lock_lost); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL async_retry got=%0d want=0", retry_cnt); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL async_fault got=%0b want=0", fault); end
      tick(); tick();
      rst_n = 1'b1;
      n = 0;
      do begin tick(); n++; end while (pll_rst === 1'b1 && n < 1000);
      total++; if (n != 100) begin bad++; $display("FAIL async_restart_len got=%0d want=100", n); end
   endtask

   task automatic test_glitch_stable();
      int seen;
      repeat (10) tick();
      pll_locked = 1'b1;
      repeat (503) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick(); tick();
      total++; if (retry_cnt !== 4'd1) begin bad++; $display("FAIL glitch_retry got=%0d want=1", retry_cnt); end
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL glitch_pll_rst got=%0b want=1", pll_rst); end
      seen = 0;
      repeat (1100) begin
         tick();
         if (ready === 1'b1) seen = 1;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL glitch_ready_pulse got=%0d want=0", seen); end
   endtask

   task automatic test_timeout();
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (299) tick();
      total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL to_wait_pll_rst got=%0b want=0", pll_rst); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL to_retry0 got=%0d want=0", retry_cnt); end
      tick();
      total++; if (retry_cnt !== 4'd1) begin bad++; $display("FAIL to_retry1 got=%0d want=1", retry_cnt); end
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL to_pll_rst1 got=%0b want=1", pll_rst); end
      repeat (300) tick();
      total++; if (retry_cnt !== 4'd2) begin bad++; $display("FAIL to_retry2 got=%0d want=2", retry_cnt); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL to_fault_early got=%0b want=0", fault); end
      repeat (300) tick();
      total++; if (retry_cnt !== 4'd3) begin bad++; $display("FAIL to_retry3 got=%0d want=3", retry_cnt); end
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL to_fault got=%0b want=1", fault); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL to_ready got=%0b want=0", ready); end
      repeat (500) tick();
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL to_fault_sticky got=%0b want=1", fault); end
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL to_pll_rst_held got=%0b want=1", pll_rst); end
      total++; if (retry_cnt !== 4'd3) begin bad++; $display("FAIL to_retry_held got=%0d want=3", retry_cnt); end
   endtask

`ifdef PLL_SUP_FREQ_CHECK_EN
   task automatic test_freq_check();
      int n;
      int seen;
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      oc_half    = 20;
      tick();
      rst_n      = 1'b1;
      pll_locked = 1'b1;
      n = 0;
      do begin tick(); n++; end while (ready !== 1'b1 && n < 2000);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL freq_ready got=%0b want=1", ready); end
      seen = 0;
      repeat (800) begin
         tick();
         if (ready !== 1'b1) seen = 1;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL freq_in_tol_drop got=%0d want=0", seen); end
      oc_half = 15;
      n = 0;
      do begin tick(); n++; end while (ready === 1'b1 && n < 500);
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL freq_out_tol got=%0b want=0", ready); end
      total++; if (retry_cnt !== 4'd1) begin bad++; $display("FAIL freq_retry got=%0d want=1", retry_cnt); end
      total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL freq_lock_lost got=%0b want=0", lock_lost); end
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      test_reset();
      test_basic_lock();
      test_lock_loss();
      test_async_reset();
      test_glitch_stable();
      test_timeout();
`ifdef PLL_SUP_FREQ_CHECK_EN
      test_freq_check();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Controller on the PLL's reset/locked interface, clocked from the 50 MHz board reference. It drives the PLL reset, qualifies the asynchronous `locked` output, and retries the PLL after a lock timeout or a lost lock. It presents a single `ready` qualifier and a `fault` flag to the audio clock-domain logic downstream.

## Interface
- `RST_CYCLES`, 100: refclk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 500000: refclk cycles allowed for synchronized `locked` to rise after `pll_rst` drops (10 ms).
- `STABLE_CYCLES`, 1024: consecutive cycles synchronized `locked` must stay high before `ready`.
- `MAX_RETRY`, 4: failed attempts tolerated before FAULT (1–15).
- `WINDOW`, 50000: refclk cycles per frequency-check window (`PLL_SUP_FREQ_CHECK_EN` only).
- `EXP_EDGES`, 12288: expected `outclk_0` rising edges per window.
- `TOL`, 16: allowed ± edge-count deviation.

Ports:
- `refclk` input 1: 50 MHz clock; the only clock.
- `rst_n` input 1: asynchronous active-low reset.
- `pll_locked` input 1: PLL `locked`, asynchronous.
- `pll_outclk` input 1: PLL `outclk_0`, sampled as data (frequency check only).
- `pll_rst` output 1: PLL reset, active-high.
- `ready` output 1: PLL output is usable.
- `fault` output 1: retries exhausted; sticky until `rst_n`.
- `lock_lost` output 1: sticky; set on any drop of lock while in RUN.
- `retry_cnt` output 4: failed attempts so far, saturating at 15.

## Operation
- `pll_locked` passes through a 2-flop synchronizer. `pll_outclk` passes through a 2-flop synchronizer plus an edge-detect flop.
- States:
  - RESET: `pll_rst`=1. Counts `RST_CYCLES`, then goes to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0. Synced lock high goes to STABLE. Timer reaching `LOCK_TIMEOUT` counts as a failure.
  - STABLE: counts consecutive high cycles. Synced lock low counts as a failure. Reaching `STABLE_CYCLES` goes to RUN.
  - RUN: `ready`=1. Synced lock low sets `lock_lost`, counts as a failure, and clears `ready` in the same cycle.
  - FAULT: `pll_rst`=1, `ready`=0, `fault`=1. Terminal.
- Failure handling: increment `retry_cnt`. If the new value ≥ `MAX_RETRY`, go to FAULT; otherwise go to RESET.
- `retry_cnt` never clears on a successful lock. Only `rst_n` clears it.
- All counters clear on every state entry.
- Counters are sized with `$clog2(param+1)` and compared with `==`. They never wrap.

## Timing
- Reset values: `pll_rst`=1, `ready`=0, `fault`=0, `lock_lost`=0, `retry_cnt`=0. State is RESET with counters at 0.
- `pll_rst` is high for exactly `RST_CYCLES` cycles after `rst_n` deassertion, then drops on the next edge.
- Lock path latency: `pll_locked` rise → synced high = 2 cycles. Then `ready` = 1 exactly `STABLE_CYCLES` cycles after entering STABLE.
- Loss latency: `pll_locked` fall → `ready` low = 3 cycles (2 sync + 1 registered state).
- A failure detected in the same cycle as the STABLE/timeout counter terminal count is treated as a failure; failure has priority.
- `rst_n` asserted mid-operation forces the reset values immediately and asynchronously, including `pll_rst`=1.
- All outputs are registered.

## Configuration
- `PLL_SUP_FREQ_CHECK_EN` defined:
  - In RUN, count synced `pll_outclk` rising edges per `WINDOW` cycles.
  - A count outside `EXP_EDGES±TOL` is a failure handled exactly like lock loss, except `lock_lost` is not set.
  - The window restarts on RUN entry.
  - Valid only while refclk > 2× outclk.
- Not defined: `pll_outclk` is ignored. The edge counter and window logic are not built.

## Test plan
- Basic lock: PLL model raises `locked` 1000 cycles after `pll_rst` falls, with defaults. → `pll_rst` high cycles 0–99; `ready` rises at 100+1000+2+1024 (±1 for the registered state transition); `retry_cnt`=0.
- Lock timeout: `locked` never asserts, `LOCK_TIMEOUT`=200, `MAX_RETRY`=3. → 3 RESET/WAIT cycles, `retry_cnt`=3, `fault`=1, `pll_rst`=1 held.
- Lock loss: after `ready`, drop `locked` for 5 cycles. → `ready` low within 3 cycles, `lock_lost`=1, `retry_cnt`=1, `pll_rst` pulses 100 cycles, then relock returns `ready` with `lock_lost` still 1.
- Glitch during STABLE: `locked` low for 1 cycle at cycle 500 of STABLE. → `retry_cnt`=1, new RESET; no `ready` pulse.
- Async reset mid-RUN: assert `rst_n`=0 between edges. → outputs at reset values before the next `refclk` edge; the sequence restarts from RESET.
- Frequency check (macro on, `WINDOW`=50000): drive `outclk` at 12.288 MHz → `ready` stays 1 across 4 windows. Switch to 12.5 MHz (12500 edges) → failure at window end, `retry_cnt`=1, `lock_lost`=0.
